// File: rtl/switch_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : switch_conditioner_if
//  Brief    : Switch-conditioner bus. Carries the raw switch levels and the
//             acknowledge in, and the stable vector and change event out.
//  Revision : 1.0 - initial release
// ============================================================================
interface switch_conditioner_if #(
    parameter int N_SW = 10
);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic            init_done;
    logic            evt_valid;
    logic [N_SW-1:0] evt_mask;
    logic [3:0]      evt_idx;
    logic            evt_multi;
    logic            evt_overrun;
    logic            evt_ack;

    // Consumer side: supplies switch levels and acknowledges events
    modport master (
        output sw_raw,
        output evt_ack,
        input  sw_stable,
        input  init_done,
        input  evt_valid,
        input  evt_mask,
        input  evt_idx,
        input  evt_multi,
        input  evt_overrun
    );

    // Conditioner side
    modport slave (
        input  sw_raw,
        input  evt_ack,
        output sw_stable,
        output init_done,
        output evt_valid,
        output evt_mask,
        output evt_idx,
        output evt_multi,
        output evt_overrun
    );
endinterface
`default_nettype wire

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : switch_conditioner
//  Brief    : Synchronizes and group-debounces the slide switches, publishes
//             a stable vector and a held, acknowledged change event.
//  Revision : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    switch_conditioner_if.slave sw_if
);

    localparam logic [0:0]      ST_INIT = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The commit fires on the edge where the count reaches its terminal value,
    // so a held change lands DEBOUNCE_CYCLES+1 edges after s1 first sees it
    // and an s2 excursion of exactly DEBOUNCE_CYCLES cycles is accepted.
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [N_SW-1:0]  ONE     = N_SW'(1);

    logic [N_SW-1:0]  sync1;
    logic [N_SW-1:0]  sync2;
    logic [N_SW-1:0]  cand;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic [N_SW-1:0]  stable;
    logic             init_done;
    logic             evt_valid;
    logic [N_SW-1:0]  evt_mask;
    logic             evt_overrun;
    logic [3:0]       evt_idx;
    logic             evt_multi;

    logic             commit;
    logic             new_change;
    logic [N_SW-1:0]  new_mask;

    assign commit     = (sync2 == cand) && (cnt >= CNT_ARM);
    assign new_change = commit && (state == ST_RUN) && (cand != stable);
    assign new_mask   = cand ^ stable;

    // Two-flop synchronizer bringing the raw switch levels into clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_if.sw_raw;
            sync2 <= sync1;
        end
    end

    // Candidate tracking: any change of the synchronized vector restarts the window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Stable-vector FSM: first commit initializes silently, later ones update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            stable    <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (commit) begin
                        stable    <= cand;
                        init_done <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                default: begin
                    if (new_change) begin
                        stable <= cand;
                    end
                end
            endcase
        end
    end

    // Event register: raise, merge into a pending event, or clear on acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid   <= 1'b0;
            evt_mask    <= '0;
            evt_overrun <= 1'b0;
        end else if (new_change) begin
            if (!evt_valid || sw_if.evt_ack) begin
                evt_valid   <= 1'b1;
                evt_mask    <= new_mask;
                evt_overrun <= 1'b0;
            end else begin
                evt_mask    <= evt_mask | new_mask;
                evt_overrun <= 1'b1;
            end
        end else if (evt_valid && sw_if.evt_ack) begin
            evt_valid   <= 1'b0;
            evt_mask    <= '0;
            evt_overrun <= 1'b0;
        end
    end

    // Lowest-set-bit index and multi-bit flag derived from the event mask
    always_comb begin
        evt_idx = 4'd0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (evt_mask[i]) begin
                evt_idx = 4'(i);
            end
        end
        evt_multi = |(evt_mask & (evt_mask - ONE));
    end

    assign sw_if.sw_stable   = stable;
    assign sw_if.init_done   = init_done;
    assign sw_if.evt_valid   = evt_valid;
    assign sw_if.evt_mask    = evt_mask;
    assign sw_if.evt_idx     = evt_idx;
    assign sw_if.evt_multi   = evt_multi;
    assign sw_if.evt_overrun = evt_overrun;

endmodule
`default_nettype wire
